// File: rtl/iter_cs_pkg.sv
// Shared types and helpers for the iterative carry-select adder.
// State encoding and counter-width helper used by iter_cs_adder.
package iter_cs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the chunk index counter; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cs_chunk_add.sv
// Combinational CHUNK-bit carry-select adder cell: two ripple chains
// (carry-in 0 and 1) computed in parallel, the real carry picks one.
module cs_chunk_add #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0]   c0;
  logic [CHUNK:0]   c1;
  logic [CHUNK-1:0] s0;
  logic [CHUNK-1:0] s1;

  assign c0[0] = 1'b0;
  assign c1[0] = 1'b1;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
    assign s0[gi]    = x[gi] ^ y[gi] ^ c0[gi];
    assign c0[gi+1]  = (x[gi] & y[gi]) | (c0[gi] & (x[gi] ^ y[gi]));
    assign s1[gi]    = x[gi] ^ y[gi] ^ c1[gi];
    assign c1[gi+1]  = (x[gi] & y[gi]) | (c1[gi] & (x[gi] ^ y[gi]));
  end

  assign s  = ci ? s1 : s0;
  assign co = ci ? c1[CHUNK] : c0[CHUNK];

endmodule

// File: rtl/iter_cs_adder.sv
// Multi-cycle WIDTH-bit adder, CHUNK bits per clock, start/busy/done handshake.
// Define ITER_CS_OVF_EN to add the signed-overflow output ovf.
module iter_cs_adder
  import iter_cs_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ITER_CS_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = idx_width(N);
  localparam int MSB  = WIDTH - 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  if ((WIDTH % CHUNK) != 0 || N < 1) begin : g_bad_cfg
    $error("iter_cs_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t            state_reg;
  logic [WIDTH-1:0]  opa_reg;
  logic [WIDTH-1:0]  opb_reg;
  logic              carry_reg;
  logic [IDXW-1:0]   idx_reg;

  logic [CHUNK-1:0]  chunk_s;
  logic              chunk_co;

  cs_chunk_add #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .x  (opa_reg[int'(idx_reg)*CHUNK +: CHUNK]),
    .y  (opb_reg[int'(idx_reg)*CHUNK +: CHUNK]),
    .ci (carry_reg),
    .s  (chunk_s),
    .co (chunk_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      opa_reg   <= '0;
      opb_reg   <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef ITER_CS_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            opa_reg   <= a;
            opb_reg   <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef ITER_CS_OVF_EN
            ovf       <= 1'b0;
`endif
            busy      <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          sum[int'(idx_reg)*CHUNK +: CHUNK] <= chunk_s;
          carry_reg <= chunk_co;
          idx_reg   <= idx_reg + 1'b1;
          if (idx_reg == LAST) begin
            // Final chunk: publish carry-out and raise the one-cycle done pulse.
            idx_reg   <= '0;
            cout      <= chunk_co;
            done      <= 1'b1;
`ifdef ITER_CS_OVF_EN
            ovf       <= (opa_reg[MSB] == opb_reg[MSB]) &&
                         (chunk_s[CHUNK-1] != opa_reg[MSB]);
`endif
            state_reg <= DONE;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_cs_adder.sv
// Randomized self-checking bench for iter_cs_adder (8/2 and 2/2 instances)
// against an integer a+b+cin reference model.
module tb_iter_cs_adder;

  localparam int N8 = 4;
  localparam int N2 = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       cin2 = 1'b0;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

`ifdef ITER_CS_OVF_EN
  logic       ovf, ovf2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  iter_cs_adder #(.WIDTH(8), .CHUNK(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef ITER_CS_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  iter_cs_adder #(.WIDTH(2), .CHUNK(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .cin   (cin2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2)
`ifdef ITER_CS_OVF_EN
    ,
    .ovf   (ovf2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete operation on the 8-bit instance; hold=1 keeps start high and
  // scrambles a/b/cin while the operation runs.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        input bit hold, input string tag);
    int         cyc;
    bit         seen;
    int         full;
    int         ssum;
    logic [7:0] exp_sum;
    logic       exp_cout;
    full     = int'(ta) + int'(tb_) + int'(tc);
    exp_sum  = full[7:0];
    exp_cout = full[8];
    ssum     = int'($signed(ta)) + int'($signed(tb_)) + int'(tc);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (hold) begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end
      if (done) seen = 1;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(N8));
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
`ifdef ITER_CS_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'((ssum > 127) || (ssum < -128)));
`endif
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_done_width"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold_sum"}, 32'(sum), 32'(exp_sum));
    $display("op %s: a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d lat=%0d",
             tag, ta, tb_, tc, sum, cout, cyc);
  endtask

  task automatic run_op2(input logic [1:0] ta, input logic [1:0] tb_, input logic tc,
                         input string tag);
    int cyc;
    bit seen;
    int full;
    full = int'(ta) + int'(tb_) + int'(tc);
    @(negedge clk);
    a2 = ta; b2 = tb_; cin2 = tc; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (done2) seen = 1;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(N2));
    check({tag, "_sum"}, 32'(sum2), 32'(full[1:0]));
    check({tag, "_cout"}, 32'(cout2), 32'(full[2]));
    @(posedge clk); #1;
    check({tag, "_done_width"}, 32'(done2), 32'd0);
    $display("op %s: a=%0b b=%0b cin=%0d -> sum=%0b cout=%0d lat=%0d",
             tag, ta, tb_, tc, sum2, cout2, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'hFF, 8'h01, 1'b0, 0, "ff_01");
    run_op(8'hA5, 8'h5A, 1'b1, 0, "a5_5a_c1");
    run_op(8'h00, 8'h00, 1'b0, 0, "zero");
    run_op(8'hFF, 8'hFF, 1'b1, 0, "max_c1");
    run_op(8'h7F, 8'h01, 1'b0, 0, "ovf_pos");
    run_op(8'h80, 8'h80, 1'b0, 0, "ovf_neg");
    run_op(8'h3C, 8'h41, 1'b0, 1, "hold_toggle");

    // Reset during the second RUN cycle: outputs clear at once, no done.
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1;
      if (i == 2) rst_n = 1'b1;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    $display("op abort: busy=%0d sum=%02h", busy, sum);
    run_op(8'h12, 8'h34, 1'b1, 0, "after_abort");

    for (int i = 0; i < 20; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)),
             $sformatf("rnd%0d", i));
    end

    run_op2(2'b11, 2'b10, 1'b1, "w2_11_10_c1");
    for (int i = 0; i < 6; i++) begin
      run_op2(2'($urandom), 2'($urandom), 1'($urandom), $sformatf("w2_rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
